// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default sizing for the program sequencer.
//   fetch_state_e : sequencer state (IDLE, RUN, DONE)
//   PC_W          : default program-counter / ROM address width
//   BT_DEPTH      : default branch-table depth
//   RS_DEPTH      : default return-stack depth
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam int PC_W     = 12;
  localparam int BT_DEPTH = 8;
  localparam int RS_DEPTH = 4;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO for call/return in the program sequencer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear (empties the stack)
//   push, din    : push din onto the stack (ignored when full)
//   pop          : discard the top entry (ignored when empty)
//   top          : current top entry (meaningful only when not empty)
//   full, empty  : occupancy flags
module ret_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = AW'(cnt);
  assign rd_idx = AW'(cnt - CW'(1));
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      cnt         <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program sequencer for the instruction ROM. Owns the program
// counter, resolves indexed branches through the ROM branch table, and
// handles start, stall, halt and end-of-program.
//
// Optional feature: define FETCH_CTRL_CALL_STACK_EN to build an S-deep
// return stack for call_en/ret_en. Without it, call_en/ret_en are ignored
// and stack_err is tied low.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin at address 0 (honoured in IDLE and DONE only)
//   stall          : hold the PC this cycle (drops branch/call/ret)
//   halt           : stop and go to DONE
//   branch_en      : jump to branch_table[branch_idx]
//   branch_idx     : branch-table index
//   branch_table   : B target addresses from the ROM
//   call_en,ret_en : call/return (optional feature)
//   prog_ctr       : ROM address
//   fetch_valid    : prog_ctr is a live instruction address
//   busy           : sequencer is running
//   done           : program finished, held until next start
//   stack_err      : sticky return-stack overflow/underflow
//
// state | meaning
// IDLE  | out of reset, waiting for start
// RUN   | fetching; one PC action per cycle
// DONE  | halted, end of memory, or stack error; waiting for start
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int  D  = PC_W,
  parameter int  B  = BT_DEPTH,
  parameter int  S  = RS_DEPTH,
  localparam int IW = (B > 1) ? $clog2(B) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic [IW-1:0] branch_idx,
  input  logic [D-1:0]  branch_table [B],
  input  logic          call_en,
  input  logic          ret_en,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done,
  output logic          stack_err
);

  fetch_state_e state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] pc_inc;
  logic         pc_last;
  logic         tbl_hit;
  logic [D-1:0] tbl_tgt;

  assign pc_inc  = pc_q + D'(1);
  assign pc_last = &pc_q;

  // Index decode by comparison so an out-of-range index (B not a power
  // of two) simply misses instead of reading past the table.
  always_comb begin
    tbl_hit = 1'b0;
    tbl_tgt = '0;
    for (int i = 0; i < B; i++) begin
      if (branch_idx == IW'(i)) begin
        tbl_hit = 1'b1;
        tbl_tgt = branch_table[i];
      end
    end
  end

`ifdef FETCH_CTRL_CALL_STACK_EN
  logic         rs_push, rs_pop, rs_clr;
  logic         rs_full, rs_empty;
  logic [D-1:0] rs_top;
  logic         err_set, err_clr;
  logic         err_q;

  ret_stack #(
    .W     (D),
    .DEPTH (S)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rs_clr),
    .push  (rs_push),
    .pop   (rs_pop),
    .din   (pc_inc),
    .top   (rs_top),
    .full  (rs_full),
    .empty (rs_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_clr) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign stack_err = err_q;
`else
  logic unused_ok;
  assign unused_ok = ^{call_en, ret_en, (S > 0)};
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_CTRL_CALL_STACK_EN
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    rs_clr  = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
`ifdef FETCH_CTRL_CALL_STACK_EN
          rs_clr  = 1'b1;
          err_clr = 1'b1;
`endif
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
        end else if (stall) begin
          pc_d = pc_q;
`ifdef FETCH_CTRL_CALL_STACK_EN
        end else if (ret_en) begin
          if (rs_empty) begin
            err_set = 1'b1;
            state_d = DONE;
          end else begin
            rs_pop = 1'b1;
            pc_d   = rs_top;
          end
        end else if (call_en) begin
          if (rs_full) begin
            err_set = 1'b1;
            state_d = DONE;
          end else begin
            // Return address wraps to 0 when calling from the last word.
            rs_push = 1'b1;
            pc_d    = tbl_hit ? tbl_tgt : pc_inc;
          end
`endif
        end else if (branch_en && tbl_hit) begin
          pc_d = tbl_tgt;
        end else if (pc_last) begin
          // Never wrap: running off the end finishes the program.
          state_d = DONE;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign prog_ctr    = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int DA = 12;
  localparam int BA = 8;
  localparam int DB = 4;
  localparam int BB = 6;
  localparam int SD = 4;
`ifdef FETCH_CTRL_CALL_STACK_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, stall, halt, branch_en, call_en, ret_en;
  logic [2:0] idx;
  logic [DA-1:0] bt_a [BA];
  logic [DB-1:0] bt_b [BB];

  logic [DA-1:0] pc_a;
  logic [DB-1:0] pc_b;
  logic fv_a, busy_a, done_a, err_a;
  logic fv_b, busy_b, done_b, err_b;

  int checks = 0;
  int errors = 0;

  // behavioural model: 0=idle 1=run 2=done, per DUT k (0 -> a, 1 -> b)
  int m_st [2];
  int m_pc [2];
  int m_sp [2];
  int m_err[2];
  int m_stk[2][SD];
  int m_d  [2] = '{DA, DB};
  int m_b  [2] = '{BA, BB};

  always #5 clk = ~clk;

  fetch_ctrl #(.D(DA), .B(BA), .S(SD)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_idx(idx), .branch_table(bt_a),
    .call_en(call_en), .ret_en(ret_en), .prog_ctr(pc_a),
    .fetch_valid(fv_a), .busy(busy_a), .done(done_a), .stack_err(err_a)
  );

  fetch_ctrl #(.D(DB), .B(BB), .S(SD)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_idx(idx), .branch_table(bt_b),
    .call_en(call_en), .ret_en(ret_en), .prog_ctr(pc_b),
    .fetch_valid(fv_b), .busy(busy_b), .done(done_b), .stack_err(err_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int tbl(input int k, input int i);
    if (k == 0) return int'(bt_a[i]);
    return int'(bt_b[i]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_pc[k] = 0; m_sp[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int lim = (1 << m_d[k]) - 1;
      int nxt = (m_pc[k] + 1) & lim;
      int ix  = int'(idx);
      if (m_st[k] == 0) begin
        if (start) begin m_st[k] = 1; m_pc[k] = 0; end
      end else if (m_st[k] == 2) begin
        if (start) begin m_st[k] = 1; m_pc[k] = 0; m_sp[k] = 0; m_err[k] = 0; end
      end else begin
        if (halt) m_st[k] = 2;
        else if (stall) m_pc[k] = m_pc[k];
        else if (CS && ret_en) begin
          if (m_sp[k] == 0) begin m_err[k] = 1; m_st[k] = 2; end
          else begin m_sp[k]--; m_pc[k] = m_stk[k][m_sp[k]]; end
        end else if (CS && call_en) begin
          if (m_sp[k] == SD) begin m_err[k] = 1; m_st[k] = 2; end
          else begin
            m_stk[k][m_sp[k]] = nxt;
            m_sp[k]++;
            m_pc[k] = tbl(k, ix);
          end
        end else if (branch_en && ix < m_b[k]) m_pc[k] = tbl(k, ix);
        else if (m_pc[k] == lim) m_st[k] = 2;
        else m_pc[k] = m_pc[k] + 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_prog_ctr", int'(pc_a), m_pc[0]);
    chk("a_fetch_valid", int'(fv_a), int'(m_st[0] == 1));
    chk("a_busy", int'(busy_a), int'(m_st[0] == 1));
    chk("a_done", int'(done_a), int'(m_st[0] == 2));
    chk("a_stack_err", int'(err_a), m_err[0]);
    chk("b_prog_ctr", int'(pc_b), m_pc[1]);
    chk("b_fetch_valid", int'(fv_b), int'(m_st[1] == 1));
    chk("b_busy", int'(busy_b), int'(m_st[1] == 1));
    chk("b_done", int'(done_b), int'(m_st[1] == 2));
    chk("b_stack_err", int'(err_b), m_err[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; halt = 0; branch_en = 0; call_en = 0; ret_en = 0; idx = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  task automatic restart();
    halt = 1; tick(); halt = 0;
    start = 1; tick(); start = 0;
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < BA; i++) bt_a[i] = '0;
    for (int i = 0; i < BB; i++) bt_b[i] = '0;
    model_reset();
    @(negedge clk);
    chk("reset_pc", int'(pc_a), 0);
    chk("reset_fetch_valid", int'(fv_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_stack_err", int'(err_a), 0);
    rst_n = 1'b1;

    // start: 0,1,2,3,4
    start = 1; tick(); start = 0;
    chk("start_pc0", int'(pc_a), 0);
    chk("start_fetch_valid", int'(fv_a), 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("count_pc", int'(pc_a), i);
    end

    // branch vs stall
    restart(); tick(); tick();
    chk("pre_branch_pc", int'(pc_a), 2);
    bt_a[3] = 12'h040; branch_en = 1; idx = 3; stall = 1;
    tick();
    chk("stall_drops_branch", int'(pc_a), 2);
    stall = 0; tick(); branch_en = 0;
    chk("branch_taken", int'(pc_a), 12'h040);

    // halt at 7
    restart();
    for (int i = 0; i < 7; i++) tick();
    chk("pre_halt_pc", int'(pc_a), 7);
    halt = 1; tick(); halt = 0;
    chk("halt_done", int'(done_a), 1);
    chk("halt_pc_held", int'(pc_a), 7);
    chk("halt_not_busy", int'(busy_a), 0);

    // reset mid-run at 9
    start = 1; tick(); start = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_reset_pc", int'(pc_a), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pc", int'(pc_a), 0);
    chk("async_reset_fv", int'(fv_a), 0);
    chk("async_reset_busy", int'(busy_a), 0);
    chk("async_reset_done", int'(done_a), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // end of memory on the 4-bit instance
    start = 1; tick(); start = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("eom_pc15", int'(pc_b), 15);
    chk("eom_not_done_yet", int'(done_b), 0);
    tick();
    chk("eom_done", int'(done_b), 1);
    chk("eom_pc_held", int'(pc_b), 15);
    start = 1; tick(); start = 0;
    chk("eom_restart_pc", int'(pc_b), 0);
    chk("eom_restart_done", int'(done_b), 0);
    chk("start_ignored_in_run", int'(pc_a), 17);

    // call / return
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_call_pc", int'(pc_a), 5);
    bt_a[1] = 12'h020; bt_b[1] = 4'h2;
    call_en = 1; idx = 1; tick(); call_en = 0;
    chk("call_pc", int'(pc_a), CS ? 32 : 6);
    ret_en = 1; tick(); ret_en = 0;
    chk("ret_pc", int'(pc_a), CS ? 6 : 7);
    call_en = 1; idx = 1;
    for (int i = 0; i < 5; i++) tick();
    call_en = 0;
    chk("overflow_err", int'(err_a), CS ? 1 : 0);
    chk("overflow_done", int'(done_a), CS ? 1 : 0);

    restart();
    chk("err_cleared_on_start", int'(err_a), 0);
    ret_en = 1; tick(); ret_en = 0;
    chk("underflow_err", int'(err_a), CS ? 1 : 0);
    chk("underflow_pc", int'(pc_a), CS ? 0 : 1);

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        for (int i = 0; i < BA; i++) bt_a[i] = DA'($urandom);
        for (int i = 0; i < BB; i++) bt_b[i] = DB'($urandom);
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      start     = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      halt      = ($urandom_range(0, 63) == 0);
      branch_en = ($urandom_range(0, 4) == 0);
      call_en   = ($urandom_range(0, 11) == 0);
      ret_en    = ($urandom_range(0, 9) == 0);
      idx       = 3'($urandom_range(0, 7));
      if (call_en) idx = 3'($urandom_range(0, BB - 1));
      tick();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
